// File: rtl/interp_pkg.sv
// Shared types and default widths for the wavetable voice path.
// Default widths are also used by the voice phase accumulator.
package interp_pkg;

  typedef enum logic [1:0] {
    LINEAR  = 2'd0,
    NEAREST = 2'd1,
    HOLD_A  = 2'd2,
    RSVD    = 2'd3
  } interp_mode_t;

  localparam int SAMPLE_W_DEF = 16;
  localparam int FRAC_W_DEF   = 6;
  localparam int CH_W_DEF     = 5;

endpackage

// File: rtl/interp_pipe_stage.sv
// Valid/ready register slice: holds data under stall, refills when empty
// or when the downstream slice is draining this cycle.
module interp_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/interpolater_pipe.sv
// Three-stage linear interpolator: A + (B-A)*frac/2^FRAC_W with optional
// rounding, per-transfer mode and channel tag pass-through.
module interpolater_pipe
  import interp_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF,
  parameter int CH_W     = CH_W_DEF,
  parameter int ROUND    = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [1:0]          IN_MODE,
  input  logic [CH_W-1:0]     IN_CH,
  input  logic [FRAC_W-1:0]   IN_FRAC,
  input  logic [SAMPLE_W-1:0] IN_A,
  input  logic [SAMPLE_W-1:0] IN_B,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [CH_W-1:0]     OUT_CH,
  output logic [SAMPLE_W-1:0] OUT_SAMPLE
);

  localparam int PW      = SAMPLE_W + FRAC_W + 2;
  localparam int S1_W    = SAMPLE_W + (SAMPLE_W + 1) + (FRAC_W + 1) + CH_W;
  localparam int S2_W    = SAMPLE_W + PW + CH_W;
  localparam int S3_W    = SAMPLE_W + CH_W;
  localparam int RND_INT = (ROUND != 0) ? (1 << (FRAC_W - 1)) : 0;

  logic v1, v2, r2, r3;
  logic [S1_W-1:0] s1_in, s1_out;
  logic [S2_W-1:0] s2_in, s2_out;
  logic [S3_W-1:0] s3_in, s3_out;

  // Stage 1 inputs: full-width difference and the mode-adjusted phase
  interp_mode_t            mode;
  logic signed [SAMPLE_W:0] diff;
  logic [FRAC_W:0]          frac_eff;

  always_comb begin
    mode     = interp_mode_t'(IN_MODE);
    diff     = $signed({IN_B[SAMPLE_W-1], IN_B}) - $signed({IN_A[SAMPLE_W-1], IN_A});
    frac_eff = '0;
    case (mode)
      NEAREST: frac_eff[FRAC_W] = IN_FRAC[FRAC_W-1];
      HOLD_A:  frac_eff = '0;
      default: frac_eff = {1'b0, IN_FRAC};
    endcase
    s1_in = {IN_A, diff, frac_eff, IN_CH};
  end

  logic [SAMPLE_W-1:0]      a1;
  logic signed [SAMPLE_W:0] d1;
  logic [FRAC_W:0]          fe1;
  logic [CH_W-1:0]          ch1;
  logic signed [PW-1:0]     d_ext, f_ext, prod;

  assign {a1, d1, fe1, ch1} = s1_out;

  always_comb begin
    d_ext = {{(PW-SAMPLE_W-1){d1[SAMPLE_W]}}, d1};
    f_ext = {{(PW-FRAC_W-1){1'b0}}, fe1};
    prod  = d_ext * f_ext;
    s2_in = {a1, prod, ch1};
  end

  logic [SAMPLE_W-1:0]  a2;
  logic signed [PW-1:0] p2, a_sh;
  logic [CH_W-1:0]      ch2;
  logic [SAMPLE_W-1:0]  sample3;

  assign {a2, p2, ch2} = s2_out;

  // Result is bounded by A and B, so truncating the shifted sum never wraps
  always_comb begin
    a_sh    = {{(PW-SAMPLE_W-FRAC_W){a2[SAMPLE_W-1]}}, a2, {FRAC_W{1'b0}}};
    sample3 = SAMPLE_W'((a_sh + p2 + PW'(RND_INT)) >>> FRAC_W);
    s3_in   = {sample3, ch2};
  end

  interp_pipe_stage #(.W(S1_W)) u_s1 (
    .clk(Clk), .rst(Reset),
    .in_valid(IN_VALID), .in_ready(IN_READY), .in_data(s1_in),
    .out_valid(v1), .out_ready(r2), .out_data(s1_out)
  );

  interp_pipe_stage #(.W(S2_W)) u_s2 (
    .clk(Clk), .rst(Reset),
    .in_valid(v1), .in_ready(r2), .in_data(s2_in),
    .out_valid(v2), .out_ready(r3), .out_data(s2_out)
  );

  interp_pipe_stage #(.W(S3_W)) u_s3 (
    .clk(Clk), .rst(Reset),
    .in_valid(v2), .in_ready(r3), .in_data(s3_in),
    .out_valid(OUT_VALID), .out_ready(OUT_READY), .out_data(s3_out)
  );

  assign {OUT_SAMPLE, OUT_CH} = s3_out;

endmodule

// File: tb/tb_interpolater_pipe.sv
// Scoreboard bench for interpolater_pipe: directed vectors, stall/backpressure,
// mid-stream reset, and a floor-mode (ROUND=0) instance.
module tb_interpolater_pipe;
  import interp_pkg::*;

  typedef struct {
    logic [15:0] sample;
    logic [4:0]  ch;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [1:0]  in_mode = 2'd0;
  logic [4:0]  in_ch = '0, out_ch;
  logic [5:0]  in_frac = '0;
  logic [15:0] in_a = '0, in_b = '0, out_sample;

  logic        f_in_valid = 1'b0, f_in_ready, f_out_valid, f_out_ready = 1'b1;
  logic [1:0]  f_in_mode = 2'd0;
  logic [4:0]  f_in_ch = '0, f_out_ch;
  logic [5:0]  f_in_frac = '0;
  logic [15:0] f_in_a = '0, f_in_b = '0, f_out_sample;

  exp_t q[$];
  exp_t qf[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   accepted = 0;

  always #5 clk = ~clk;

  interpolater_pipe u_dut (
    .Clk(clk), .Reset(rst),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_MODE(in_mode), .IN_CH(in_ch),
    .IN_FRAC(in_frac), .IN_A(in_a), .IN_B(in_b),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_CH(out_ch), .OUT_SAMPLE(out_sample)
  );

  interpolater_pipe #(.SAMPLE_W(16), .FRAC_W(6), .CH_W(5), .ROUND(0)) u_dut_floor (
    .Clk(clk), .Reset(rst),
    .IN_VALID(f_in_valid), .IN_READY(f_in_ready), .IN_MODE(f_in_mode), .IN_CH(f_in_ch),
    .IN_FRAC(f_in_frac), .IN_A(f_in_a), .IN_B(f_in_b),
    .OUT_VALID(f_out_valid), .OUT_READY(f_out_ready), .OUT_CH(f_out_ch), .OUT_SAMPLE(f_out_sample)
  );

  // Monitors: compare the queue head whenever an output is presented;
  // pop only on an actual transfer, so stalled outputs are rechecked each cycle.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got sample=%0d ch=%0d, required no output", $signed(out_sample), out_ch);
      end else begin
        if (out_sample !== q[0].sample || out_ch !== q[0].ch) begin
          n_bad++;
          $display("FAIL %s: got sample=%0d ch=%0d, required sample=%0d ch=%0d",
                   q[0].name, $signed(out_sample), out_ch, $signed(q[0].sample), q[0].ch);
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && f_out_valid) begin
      n_cmp++;
      if (qf.size() == 0) begin
        n_bad++;
        $display("FAIL floor_unexpected_out: got sample=%0d, required no output", $signed(f_out_sample));
      end else begin
        if (f_out_sample !== qf[0].sample || f_out_ch !== qf[0].ch) begin
          n_bad++;
          $display("FAIL %s: got sample=%0d ch=%0d, required sample=%0d ch=%0d",
                   qf[0].name, $signed(f_out_sample), f_out_ch, $signed(qf[0].sample), qf[0].ch);
        end
        if (f_out_ready) void'(qf.pop_front());
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input bit sel, input logic [1:0] mode, input logic [4:0] ch,
                      input logic [5:0] frac, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp_s, input string nm);
    exp_t e;
    logic rdy;
    bit   done;
    e.sample = exp_s; e.ch = ch; e.name = nm;
    done = 0;
    if (sel) begin
      f_in_valid = 1; f_in_mode = mode; f_in_ch = ch; f_in_frac = frac; f_in_a = a; f_in_b = b;
    end else begin
      in_valid = 1; in_mode = mode; in_ch = ch; in_frac = frac; in_a = a; in_b = b;
    end
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      rdy = sel ? f_in_ready : in_ready;
      @(posedge clk); #1;
      if (rdy) done = 1;
    end
    if (done) begin
      if (sel) qf.push_back(e); else q.push_back(e);
      accepted++;
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL %s_accept_timeout: got no accept, required accept within 50 cycles", nm);
    end
    if (sel) f_in_valid = 0; else in_valid = 0;
  endtask

  task automatic drain(input string nm);
    bit empty;
    empty = 0;
    for (int t = 0; t < 100 && !empty; t++) begin
      @(negedge clk);
      if (q.size() == 0 && qf.size() == 0) empty = 1;
    end
    n_cmp++;
    if (!empty) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d+%0d pending, required 0", nm, q.size(), qf.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_sample", {16'd0, out_sample}, 32'd0);
    chk("rst_out_ch",     {27'd0, out_ch},     32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Latency: accept edge E0, OUT_VALID rises after E2
    in_valid = 1; in_mode = LINEAR; in_ch = 5'd1; in_frac = 6'd32; in_a = 16'd0; in_b = 16'd1000;
    e.sample = 16'd500; e.ch = 5'd1; e.name = "lin_half";
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk); chk("lat_c1", {31'd0, out_valid}, 32'd0);
    @(negedge clk); chk("lat_c2", {31'd0, out_valid}, 32'd0);
    @(negedge clk); chk("lat_c3", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    drain("lat");

    send(0, LINEAR,  5'd2, 6'd0,  16'd0,      16'd1000,   16'd0,      "lin_frac0");
    send(0, LINEAR,  5'd3, 6'd63, 16'd0,      16'd1000,   16'd984,    "lin_frac63");
    send(0, LINEAR,  5'd4, 6'd63, 16'h8000,   16'h7FFF,   16'd31743,  "swing_up");
    send(0, LINEAR,  5'd5, 6'd1,  16'h7FFF,   16'h8000,   16'd31743,  "swing_down");
    send(0, NEAREST, 5'd6, 6'd31, 16'd100,    16'd200,    16'd100,    "near_31");
    send(0, NEAREST, 5'd7, 6'd32, 16'd100,    16'd200,    16'd200,    "near_32");
    send(0, HOLD_A,  5'd8, 6'd63, 16'd100,    16'd200,    16'd100,    "hold_a");
    send(0, RSVD,    5'd9, 6'd32, 16'd0,      16'd1000,   16'd500,    "rsvd_linear");
    send(0, LINEAR,  5'd10, 6'd32, 16'd0,     16'hFFFF,   16'd0,      "round_neg_half");
    send(1, LINEAR,  5'd11, 6'd32, 16'd0,     16'hFFFF,   16'hFFFF,   "floor_neg_half");
    send(1, LINEAR,  5'd12, 6'd32, 16'd0,     16'd1000,   16'd500,    "floor_half");
    drain("vectors");

    // Backpressure: 8 back-to-back with output stalled for the first cycles;
    // D=64, frac=8k gives A+8k => 108k for A=100k
    accepted = 0;
    out_ready = 0;
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(0, LINEAR, 5'(k), 6'(8 * k), 16'(100 * k), 16'(100 * k + 64), 16'(108 * k), "stream");
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_accepts", 32'(accepted), 32'd3);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    drain("stream");

    // Reset with the pipe full: everything in flight is discarded
    out_ready = 0;
    send(0, LINEAR, 5'd20, 6'd32, 16'd0, 16'd1000, 16'd500, "flush0");
    send(0, LINEAR, 5'd21, 6'd32, 16'd0, 16'd1000, 16'd500, "flush1");
    send(0, LINEAR, 5'd22, 6'd32, 16'd0, 16'd1000, 16'd500, "flush2");
    chk("full_before_rst", {31'd0, out_valid}, 32'd1);
    rst = 1;
    #1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_mid_sample",    {16'd0, out_sample}, 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 0;
    out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_stale_out", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    send(0, LINEAR, 5'd23, 6'd63, 16'd0, 16'd1000, 16'd984, "after_rst");
    drain("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
